// File: rtl/fourier_power_peak.sv
// Power-spectrum stage behind the DFT engine: kicks the transform, reads back
// each bin, computes re^2 + im^2 with one shared multiplier and one adder,
// buffers the powers for random-access readout and tracks the peak bin.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; done/peak hold results of the last run
// KICK    | dft_op=10 held until the engine reports dft_done
// REQ     | dft_op=11, dft_addr=k; engine registers bin k at end of cycle
// CAPT    | capture engine y_re/y_im into re_q/im_q
// SQ_RE   | acc <= re_q*re_q
// SQ_IM   | acc <= acc + im_q*im_q
// STORE   | write acc to buffer, update peak, advance k or finish
module fourier_power_peak #(
  parameter int N = 100,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [1:0]   dft_op,
  output logic [31:0]  dft_addr,
  input  logic [W-1:0] dft_re,
  input  logic [W-1:0] dft_im,
  input  logic         dft_done,
  input  logic         rd_en,
  input  logic [31:0]  rd_addr,
  output logic [W-1:0] pwr,
  output logic [31:0]  peak_bin,
  output logic [W-1:0] peak_pwr,
  output logic         busy,
  output logic         done
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_REQ,
    S_CAPT,
    S_SQ_RE,
    S_SQ_IM,
    S_STORE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [31:0]    k;
  logic [W-1:0]   re_q;
  logic [W-1:0]   im_q;
  logic [W-1:0]   acc;
  logic [W-1:0]   pwr_buf [N];

  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_p;
  logic [W-1:0]   add_b;
  logic [W-1:0]   sum;
  logic           last;
  logic [AW-1:0]  k_idx;
  logic [AW-1:0]  rd_idx;

  assign last   = (k == 32'(N - 1));
  assign k_idx  = k[AW-1:0];
  assign rd_idx = rd_addr[AW-1:0];

  // Shared datapath: the multiplier squares re_q or im_q, the adder folds in acc
  // only on the imaginary pass so the real pass starts from zero.
  always_comb begin
    mul_a = re_q;
    add_b = '0;
    if (state == S_SQ_IM) begin
      mul_a = im_q;
      add_b = acc;
    end
    mul_p = mul_a * mul_a;
    sum   = mul_p + add_b;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and engine command decode.
  always_comb begin
    state_nxt = state;
    dft_op    = 2'b00;
    dft_addr  = k;
    case (state)
      S_IDLE: begin
        dft_addr = '0;
        if (start) state_nxt = S_KICK;
      end
      S_KICK: begin
        dft_op   = 2'b10;
        dft_addr = '0;
        if (dft_done) state_nxt = S_REQ;
      end
      S_REQ: begin
        dft_op    = 2'b11;
        state_nxt = S_CAPT;
      end
      S_CAPT:  state_nxt = S_SQ_RE;
      S_SQ_RE: state_nxt = S_SQ_IM;
      S_SQ_IM: state_nxt = S_STORE;
      S_STORE: state_nxt = last ? S_IDLE : S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run control, operand capture, accumulation and peak tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k        <= '0;
      re_q     <= '0;
      im_q     <= '0;
      acc      <= '0;
      peak_bin <= '0;
      peak_pwr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done     <= 1'b0;
            busy     <= 1'b1;
            k        <= '0;
            peak_bin <= '0;
            peak_pwr <= '0;
          end
        end
        S_CAPT: begin
          re_q <= dft_re;
          im_q <= dft_im;
        end
        S_SQ_RE, S_SQ_IM: acc <= sum;
        S_STORE: begin
          // Strict compare keeps the lowest index on ties.
          if (acc > peak_pwr) begin
            peak_pwr <= acc;
            peak_bin <= k;
          end
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            k <= k + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Power buffer write and registered read port; out-of-range reads return 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) pwr_buf[i] <= '0;
      pwr <= '0;
    end else begin
      if (state == S_STORE) pwr_buf[k_idx] <= acc;
      if (rd_en) pwr <= (rd_addr < 32'(N)) ? pwr_buf[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_fourier_power_peak.sv
// Bench for fourier_power_peak with a small behavioural DFT engine (N=4).
module tb_fourier_power_peak;

  localparam int N = 4;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   dft_op;
  logic [31:0]  dft_addr;
  logic [W-1:0] dft_re;
  logic [W-1:0] dft_im;
  logic         dft_done;
  logic         rd_en;
  logic [31:0]  rd_addr;
  logic [W-1:0] pwr;
  logic [31:0]  peak_bin;
  logic [W-1:0] peak_pwr;
  logic         busy;
  logic         done;

  logic [W-1:0] re_tab [0:N-1];
  logic [W-1:0] im_tab [0:N-1];
  logic [W-1:0] exp_pwr [0:N-1];
  logic [W-1:0] exp_peak;
  logic [31:0]  exp_bin;
  logic [31:0]  req_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  fourier_power_peak #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dft_op(dft_op), .dft_addr(dft_addr),
    .dft_re(dft_re), .dft_im(dft_im), .dft_done(dft_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .pwr(pwr),
    .peak_bin(peak_bin), .peak_pwr(peak_pwr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Engine model: registers the addressed bin when asked with op 11.
  always @(posedge clk) begin
    if (dft_op == 2'b11) begin
      dft_re <= re_tab[dft_addr[1:0]];
      dft_im <= im_tab[dft_addr[1:0]];
      req_q.push_back(dft_addr);
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: power = re^2 + im^2 mod 2^64; peak = first index of maximum.
  task automatic model();
    exp_peak = '0;
    exp_bin  = '0;
    for (int i = 0; i < N; i++) begin
      exp_pwr[i] = re_tab[i] * re_tab[i] + im_tab[i] * im_tab[i];
      if (exp_pwr[i] > exp_peak) begin
        exp_peak = exp_pwr[i];
        exp_bin  = i;
      end
    end
  endtask

  task automatic rd(input logic [31:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en   = 1'b0;
  endtask

  // Start a run (optionally re-pulsing start mid-run) and wait for done.
  // cyc counts negedges after the start edge, the first being 1.
  task automatic run(input string tag, input bit tcheck, input int extra_at);
    int cyc;
    model();
    req_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_start"}, W'(busy), W'(1));
    chk({tag, "_done_clr"}, W'(done), W'(0));
    while (!done && cyc < 2000) begin
      start = (cyc == extra_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done"}, W'(done), W'(1));
    if (tcheck) chk({tag, "_latency"}, W'(cyc), W'(5 * N + 2));
    chk({tag, "_busy_end"}, W'(busy), W'(0));
    chk({tag, "_peak_bin"}, W'(peak_bin), W'(exp_bin));
    chk({tag, "_peak_pwr"}, peak_pwr, exp_peak);
    for (int i = 0; i < N; i++) begin
      rd(i);
      chk($sformatf("%s_pwr%0d", tag, i), pwr, exp_pwr[i]);
    end
    rd(7);
    chk({tag, "_pwr_oob"}, pwr, '0);
  endtask

  initial begin
    int guard;
    reset = 1'b0; start = 1'b0; dft_done = 1'b1; rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < N; i++) begin re_tab[i] = '0; im_tab[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_op", W'(dft_op), W'(0));
    chk("rst_addr", W'(dft_addr), W'(0));
    chk("rst_pwr", pwr, '0);
    chk("rst_peak_bin", W'(peak_bin), W'(0));
    chk("rst_peak_pwr", peak_pwr, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    reset = 1'b1;
    @(negedge clk);

    // Basic run, engine already done.
    re_tab = '{64'd3, 64'd0, 64'd1, 64'd2};
    im_tab = '{64'd4, 64'd0, 64'd1, 64'd2};
    run("basic", 1'b1, 0);
    chk("basic_peak_const", peak_pwr, 64'd25);

    // Tie keeps lowest index.
    re_tab = '{64'd0, 64'd5, 64'd5, 64'd0};
    im_tab = '{64'd0, 64'd0, 64'd0, 64'd0};
    run("tie", 1'b1, 0);
    chk("tie_bin_const", W'(peak_bin), W'(1));

    // Modular wrap of products.
    re_tab = '{64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd0};
    im_tab = '{64'd0, 64'd0, 64'd0, 64'd0};
    run("wrap", 1'b1, 0);
    chk("wrap_peak_const", peak_pwr, 64'd9);

    // All zero powers.
    re_tab = '{64'd0, 64'd0, 64'd0, 64'd0};
    run("zero", 1'b1, 0);

    // Handshake: engine not done for 50 cycles.
    re_tab = '{64'd1, 64'd7, 64'd2, 64'd3};
    im_tab = '{64'd1, 64'd1, 64'd9, 64'd0};
    dft_done = 1'b0;
    req_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      chk("hs_op", W'(dft_op), W'(2'b10));
      chk("hs_busy", W'(busy), W'(1));
      @(negedge clk);
    end
    dft_done = 1'b1;
    model();
    guard = 0;
    while (!done && guard < 2000) begin @(negedge clk); guard++; end
    chk("hs_done", W'(done), W'(1));
    chk("hs_req_cnt", W'(req_q.size()), W'(N));
    for (int i = 0; i < N; i++)
      chk($sformatf("hs_req%0d", i), (i < req_q.size()) ? W'(req_q[i]) : '1, W'(i));
    chk("hs_peak_bin", W'(peak_bin), W'(exp_bin));
    chk("hs_peak_pwr", peak_pwr, exp_peak);

    // Start pulsed while busy is ignored.
    run("restart", 1'b1, 9);

    // Randomised runs: full-width and small values (small ones tie often).
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r < 2) begin
          re_tab[i] = {$urandom, $urandom};
          im_tab[i] = {$urandom, $urandom};
        end else begin
          re_tab[i] = 64'($urandom_range(0, 3));
          im_tab[i] = 64'($urandom_range(0, 3));
        end
      end
      run($sformatf("rnd%0d", r), 1'b1, 0);
    end

    // Reset during SQ_IM of bin 2.
    re_tab = '{64'd3, 64'd0, 64'd1, 64'd2};
    im_tab = '{64'd4, 64'd0, 64'd1, 64'd2};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(dft_op == 2'b11 && dft_addr == 32'd2) && guard < 200) begin
      @(negedge clk); guard++;
    end
    chk("ar_reach_bin2", W'(dft_addr), W'(2));
    repeat (3) @(negedge clk);
    chk("ar_peak_before", peak_pwr, 64'd25);
    reset = 1'b0;
    @(negedge clk);
    chk("ar_op", W'(dft_op), W'(0));
    chk("ar_addr", W'(dft_addr), W'(0));
    chk("ar_pwr", pwr, '0);
    chk("ar_peak_bin", W'(peak_bin), W'(0));
    chk("ar_peak_pwr", peak_pwr, '0);
    chk("ar_busy", W'(busy), W'(0));
    chk("ar_done", W'(done), W'(0));
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rd(i);
      chk($sformatf("ar_buf%0d", i), pwr, '0);
    end
    run("after_rst", 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fourier_power_peak.md
Name: fourier_power_peak

Overview:
Downstream stage of the 64-bit DFT engine. It kicks the transform with operation 2'b10 and waits for the engine's done. It then reads every output bin through the engine's operation 2'b11 / addr port and computes the power re*re + im*im per bin, using one shared multiplier and one shared adder. Power values are stored in a local buffer readable by address, and the block tracks the peak bin for the downstream decision logic.

Parameters:
N, 100, number of DFT bins; must match the engine's n
W, 64, data width of engine outputs and power values

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a run when idle
dft_op  out  2  operation bus to the DFT engine
dft_addr  out  32  bin address to the DFT engine
dft_re  in  W  engine y_re
dft_im  in  W  engine y_im
dft_done  in  1  engine done
rd_en  in  1  power-buffer read strobe
rd_addr  in  32  power-buffer read address
pwr  out  W  registered power read data
peak_bin  out  32  index of the maximum-power bin
peak_pwr  out  W  maximum power value
busy  out  1  high from accepted start until done
done  out  1  sticky; high after a run completes, cleared by the next accepted start

Behaviour:
- Reset (reset==0 at a clk edge):
  - All state returns to IDLE.
  - Outputs: dft_op=00, dft_addr=0, pwr=0, peak_bin=0, peak_pwr=0, busy=0, done=0.
  - Bin counter k=0; all N power-buffer entries cleared to 0.
  - Reset mid-run aborts immediately; no partial peak is kept.
- dft_op and dft_addr are combinational from state and k:
  - IDLE: 00 / 0
  - KICK: 10 / 0
  - REQ: 11 / k
  - all other states: 00 / k
- FSM:
  - IDLE: start=1 -> KICK; done<=0, busy<=1, k<=0, peak_bin<=0, peak_pwr<=0. start while busy is ignored.
  - KICK: hold dft_op=10. dft_done=1 -> REQ. There is no timeout; the block waits indefinitely.
  - REQ: one cycle. The engine registers y_re/y_im at the end of this cycle.
  - CAPT: re_q<=dft_re, im_q<=dft_im.
  - SQ_RE: acc<=re_q*re_q.
  - SQ_IM: acc<=acc+im_q*im_q (the one adder and one multiplier are shared).
  - STORE: buf[k]<=acc. If acc>peak_pwr (strict, unsigned): peak_pwr<=acc, peak_bin<=k.
    - If k==N-1: -> IDLE, busy<=0, done<=1.
    - Else: k<=k+1 -> REQ.
- Arithmetic:
  - Operands are W-bit unsigned.
  - Products and sum are truncated to W bits (modulo 2^W), consistent with the engine's modular datapath.
  - Ties keep the lowest bin index.
  - If all powers are 0, the result is peak_bin=0, peak_pwr=0.
- Timing:
  - 5 cycles per bin.
  - If dft_done is already high, done is first high 5N+2 cycles after the edge that samples start (1 cycle KICK + 5N + register).
- Read port:
  - rd_en=1 at an edge: pwr<=buf[rd_addr] if rd_addr<N, else pwr<=0. Latency is 1 cycle.
  - With rd_en=0, pwr holds its value.
  - Reads are allowed while busy and return the current (possibly stale) buffer contents.
  - A read of bin k in the same cycle as its STORE returns the old value.
- done stays high until the next accepted start. peak_bin/peak_pwr hold until the next accepted start.

Test Plan:
- N=4, behavioral engine model with re={3,0,1,2}, im={4,0,1,2}; start -> pwr reads {25,0,2,8}, peak_bin=0, peak_pwr=25. done first high exactly 22 cycles after the start edge (dft_done pre-asserted).
- Tie: re={0,5,5,0}, im=0 -> peak_bin=1, peak_pwr=25.
- Wrap and sign: re[0]=2^32, re[1]=0xFFFF_FFFF_FFFF_FFFD, im=0 -> pwr[0]=0, pwr[1]=9, peak_bin=1.
- Handshake: hold dft_done=0 for 50 cycles -> dft_op stays 10 and busy=1 throughout. Raise dft_done -> REQ sequence issues dft_op=11 with dft_addr 0,1,2,3 in order.
- start pulsed while busy -> ignored; peak/done identical to a single run. rd_addr=7 (>=N) -> pwr=0.
- Assert reset low during SQ_IM of bin 2 -> next cycle all outputs 0, dft_op=00, buffer reads 0. A fresh start completes correctly.
